// File: rtl/camera_scroll_pkg.sv
// Shared geometry and FSM encoding for the camera scroll block and the renderers
// that consume its offsets.
package camera_scroll_pkg;
    localparam int OFFSET_W   = 13;
    localparam int H_ACTIVE   = 1024;
    localparam int V_ACTIVE   = 768;
    localparam int WORLD_W    = 2048;
    localparam int WORLD_H    = 8000;
    localparam int CENTER_X   = 512;
    localparam int CENTER_Y   = 384;
    localparam int DEADZONE_X = 64;
    localparam int DEADZONE_Y = 96;
    localparam int MAX_STEP   = 8;
    localparam int MAX_X      = WORLD_W - H_ACTIVE;
    localparam int MAX_Y      = WORLD_H - V_ACTIVE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CALC,
        ST_STEP,
        ST_COMMIT
    } state_e;
endpackage

// File: rtl/camera_scroll_axis_step.sv
// Per-axis camera datapath: clamp target to the scrollable range, form the error,
// and derive the next offset from the dead zone and step limit.
module axis_step
    import camera_scroll_pkg::*;
#(
    parameter int CENTER   = 0,
    parameter int LIMIT    = 0,
    parameter int DEADZONE = 0,
    parameter int STEP_MAX = MAX_STEP
) (
    input  logic [OFFSET_W-1:0]        target,
    input  logic [OFFSET_W-1:0]        cur,
    input  logic                       snap,
    input  logic [OFFSET_W-1:0]        des_in,
    input  logic signed [OFFSET_W:0]   err_in,
    output logic [OFFSET_W-1:0]        des_out,
    output logic signed [OFFSET_W:0]   err_out,
    output logic [OFFSET_W-1:0]        nxt
);
    logic signed [OFFSET_W:0] raw;
    logic [OFFSET_W:0]        mag;
    logic [OFFSET_W:0]        stp;

    always_comb begin
        raw = $signed({1'b0, target}) - $signed((OFFSET_W+1)'(CENTER));
        if (raw < 0)
            des_out = '0;
        else if (raw > $signed((OFFSET_W+1)'(LIMIT)))
            des_out = OFFSET_W'(LIMIT);
        else
            des_out = raw[OFFSET_W-1:0];
        err_out = $signed({1'b0, des_out}) - $signed({1'b0, cur});
    end

    // Step never exceeds |err|-DEADZONE, so the result cannot overshoot the clamped target.
    always_comb begin
        mag = (err_in < 0) ? (OFFSET_W+1)'(-err_in) : (OFFSET_W+1)'(err_in);
        stp = '0;
        nxt = cur;
        if (snap) begin
            nxt = des_in;
        end else if (mag > (OFFSET_W+1)'(DEADZONE)) begin
            stp = mag - (OFFSET_W+1)'(DEADZONE);
            if (stp > (OFFSET_W+1)'(STEP_MAX))
                stp = (OFFSET_W+1)'(STEP_MAX);
            nxt = (err_in < 0) ? cur - stp[OFFSET_W-1:0] : cur + stp[OFFSET_W-1:0];
        end
    end
endmodule

// File: rtl/camera_scroll.sv
// Per-frame camera tracker: once per vertical blank, walks screenx/screeny toward
// the climber and commits both offsets in a single cycle so renderers never tear.
module camera_scroll
    import camera_scroll_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [10:0]         hcount,
    input  logic [9:0]          vcount,
    input  logic                enable,
    input  logic                snap,
    input  logic [OFFSET_W-1:0] target_x,
    input  logic [OFFSET_W-1:0] target_y,
    output logic [OFFSET_W-1:0] screenx,
    output logic [OFFSET_W-1:0] screeny,
    output logic                scrolling
);
    state_e                   state_q, state_d;
    logic                     fs_prev_q, fs_cond, strobe;
    logic                     snap_pend_q, snap_pend_d, snap_lat_q, snap_lat_d;
    logic [OFFSET_W-1:0]      tx_q, tx_d, ty_q, ty_d;
    logic [OFFSET_W-1:0]      desx_q, desx_d, desy_q, desy_d;
    logic signed [OFFSET_W:0] errx_q, errx_d, erry_q, erry_d;
    logic [OFFSET_W-1:0]      newx_q, newx_d, newy_q, newy_d;
    logic [OFFSET_W-1:0]      screenx_q, screenx_d, screeny_q, screeny_d;
    logic                     scrolling_q, scrolling_d;
    logic [OFFSET_W-1:0]      desx_c, desy_c, nxtx_c, nxty_c;
    logic signed [OFFSET_W:0] errx_c, erry_c;

    axis_step #(.CENTER(CENTER_X), .LIMIT(MAX_X), .DEADZONE(DEADZONE_X)) u_x (
        .target(tx_q), .cur(screenx_q), .snap(snap_lat_q), .des_in(desx_q), .err_in(errx_q),
        .des_out(desx_c), .err_out(errx_c), .nxt(nxtx_c)
    );
    axis_step #(.CENTER(CENTER_Y), .LIMIT(MAX_Y), .DEADZONE(DEADZONE_Y)) u_y (
        .target(ty_q), .cur(screeny_q), .snap(snap_lat_q), .des_in(desy_q), .err_in(erry_q),
        .des_out(desy_c), .err_out(erry_c), .nxt(nxty_c)
    );

    assign fs_cond = (hcount == 11'd0) && (vcount == 10'(V_ACTIVE));
    assign strobe  = fs_cond && !fs_prev_q;

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        snap_lat_d  = snap_lat_q;
        desx_d      = desx_q;
        desy_d      = desy_q;
        errx_d      = errx_q;
        erry_d      = erry_q;
        newx_d      = newx_q;
        newy_d      = newy_q;
        screenx_d   = screenx_q;
        screeny_d   = screeny_q;
        scrolling_d = scrolling_q;
        // A snap landing on the COMMIT cycle survives into the next frame.
        snap_pend_d = snap || (snap_pend_q && (state_q != ST_COMMIT));
        case (state_q)
            ST_IDLE:    if (strobe && enable) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                tx_d       = target_x;
                ty_d       = target_y;
                snap_lat_d = snap_pend_q;
                state_d    = ST_CALC;
            end
            ST_CALC: begin
                desx_d  = desx_c;
                desy_d  = desy_c;
                errx_d  = errx_c;
                erry_d  = erry_c;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                newx_d  = nxtx_c;
                newy_d  = nxty_c;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                screenx_d   = newx_q;
                screeny_d   = newy_q;
                scrolling_d = (newx_q != screenx_q) || (newy_q != screeny_q);
                state_d     = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            fs_prev_q   <= 1'b0;
            snap_pend_q <= 1'b0;
            snap_lat_q  <= 1'b0;
            tx_q        <= '0;
            ty_q        <= '0;
            desx_q      <= '0;
            desy_q      <= '0;
            errx_q      <= '0;
            erry_q      <= '0;
            newx_q      <= '0;
            newy_q      <= '0;
            screenx_q   <= '0;
            screeny_q   <= OFFSET_W'(MAX_Y);
            scrolling_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fs_prev_q   <= fs_cond;
            snap_pend_q <= snap_pend_d;
            snap_lat_q  <= snap_lat_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            desx_q      <= desx_d;
            desy_q      <= desy_d;
            errx_q      <= errx_d;
            erry_q      <= erry_d;
            newx_q      <= newx_d;
            newy_q      <= newy_d;
            screenx_q   <= screenx_d;
            screeny_q   <= screeny_d;
            scrolling_q <= scrolling_d;
        end
    end

    assign screenx   = screenx_q;
    assign screeny   = screeny_q;
    assign scrolling = scrolling_q;
endmodule

// File: tb/tb_camera_scroll.sv
// Bench for camera_scroll: directed frame table, latency/reset corner sequences,
// then random frames against a frame-level reference model.
module tb_camera_scroll;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount = 11'd1;
    logic [9:0]  vcount = 10'd0;
    logic        enable = 1'b0;
    logic        snap = 1'b0;
    logic [12:0] target_x = '0;
    logic [12:0] target_y = '0;
    logic [12:0] screenx, screeny;
    logic        scrolling;

    int checks = 0;
    int errors = 0;

    camera_scroll dut (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .enable(enable), .snap(snap), .target_x(target_x), .target_y(target_y),
        .screenx(screenx), .screeny(screeny), .scrolling(scrolling)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit en;
        bit sn;
        int tx;
        int ty;
        int ex;
        int ey;
        bit es;
    } vec_t;

    vec_t tbl[13];

    int m_x, m_y;
    bit m_scr, m_pend;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_snap();
        @(negedge clock) snap = 1'b1;
        @(negedge clock) snap = 1'b0;
    endtask

    task automatic run_frame(input int hold);
        @(negedge clock);
        hcount = 11'd0;
        vcount = 10'd768;
        repeat (hold) @(negedge clock);
        hcount = 11'd1;
        vcount = 10'd0;
        repeat (8) @(negedge clock);
    endtask

    // Frame-level reference: one update per enabled frame, from the rules directly.
    function automatic int ax_model(int cur, int tgt, int center, int lim, int dz, bit sn);
        int d, e, a, s;
        d = tgt - center;
        if (d < 0) d = 0;
        if (d > lim) d = lim;
        if (sn) return d;
        e = d - cur;
        a = (e < 0) ? -e : e;
        if (a <= dz) return cur;
        s = a - dz;
        if (s > 8) s = 8;
        return (e < 0) ? cur - s : cur + s;
    endfunction

    task automatic model_frame(input bit en, input int tx, input int ty);
        int nx, ny;
        if (!en) return;
        nx = ax_model(m_x, tx, 512, 1024, 64, m_pend);
        ny = ax_model(m_y, ty, 384, 7232, 96, m_pend);
        m_scr  = (nx != m_x) || (ny != m_y);
        m_x    = nx;
        m_y    = ny;
        m_pend = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1, 0,  540, 7616,    0, 7232, 0};
        tbl[1]  = '{1, 0, 1000, 7616,    8, 7232, 1};
        tbl[2]  = '{1, 0, 1000, 7616,   16, 7232, 1};
        tbl[3]  = '{1, 0, 1000, 7616,   24, 7232, 1};
        tbl[4]  = '{0, 0, 2000, 7616,   24, 7232, 1};
        tbl[5]  = '{0, 0, 2000, 7616,   24, 7232, 1};
        tbl[6]  = '{0, 0, 2000, 7616,   24, 7232, 1};
        tbl[7]  = '{1, 1, 4000, 7616, 1024, 7232, 1};
        tbl[8]  = '{1, 0, 1536,    0, 1024, 7224, 1};
        tbl[9]  = '{1, 0, 1536,    0, 1024, 7216, 1};
        tbl[10] = '{1, 1, 1536,    0, 1024,    0, 1};
        tbl[11] = '{1, 0, 1536,    0, 1024,    0, 0};
        tbl[12] = '{1, 0,    0,    0, 1016,    0, 1};

        #12;
        chk("reset_screenx", int'(screenx), 0);
        chk("reset_screeny", int'(screeny), 7232);
        chk("reset_scrolling", int'(scrolling), 0);
        @(negedge clock) reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            enable   = tbl[i].en;
            target_x = 13'(tbl[i].tx);
            target_y = 13'(tbl[i].ty);
            if (tbl[i].sn) pulse_snap();
            run_frame(1);
            chk($sformatf("tbl%0d_screenx", i), int'(screenx), tbl[i].ex);
            chk($sformatf("tbl%0d_screeny", i), int'(screeny), tbl[i].ey);
            chk($sformatf("tbl%0d_scrolling", i), int'(scrolling), int'(tbl[i].es));
        end

        // Asynchronous reset away from any clock edge.
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_screenx", int'(screenx), 0);
        chk("async_rst_screeny", int'(screeny), 7232);
        chk("async_rst_scrolling", int'(scrolling), 0);
        @(negedge clock) reset_n = 1'b1;

        // Exact latency: new value appears on the 4th edge after the strobe edge.
        enable   = 1'b1;
        target_x = 13'd1000;
        target_y = 13'd7616;
        @(negedge clock);
        hcount = 11'd0;
        vcount = 10'd768;
        @(negedge clock);
        hcount = 11'd1;
        vcount = 10'd0;
        repeat (3) @(negedge clock);
        chk("latency_before", int'(screenx), 0);
        @(negedge clock);
        chk("latency_after", int'(screenx), 8);
        chk("latency_scrolling", int'(scrolling), 1);
        repeat (4) @(negedge clock);

        // Frame condition held for several cycles still yields a single step.
        run_frame(4);
        chk("held_cond_screenx", int'(screenx), 16);

        // Reset landing in CALC discards the in-flight update.
        @(negedge clock);
        hcount = 11'd0;
        vcount = 10'd768;
        @(negedge clock);
        hcount = 11'd1;
        vcount = 10'd0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("calc_rst_screenx", int'(screenx), 0);
        @(negedge clock) reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("calc_rst_nocommit_x", int'(screenx), 0);
        chk("calc_rst_nocommit_y", int'(screeny), 7232);
        chk("calc_rst_scrolling", int'(scrolling), 0);

        // Random frames against the reference model, starting from reset state.
        m_x = 0;
        m_y = 7232;
        m_scr = 1'b0;
        m_pend = 1'b0;
        for (int f = 0; f < 40; f++) begin
            bit en, sn;
            int tx, ty;
            en = ($urandom_range(0, 3) != 0);
            sn = ($urandom_range(0, 3) == 0);
            tx = int'($urandom_range(0, 8191));
            ty = int'($urandom_range(0, 8191));
            enable   = en;
            target_x = 13'(tx);
            target_y = 13'(ty);
            if (sn) begin
                pulse_snap();
                m_pend = 1'b1;
            end
            run_frame(1);
            model_frame(en, tx, ty);
            chk($sformatf("rnd%0d_screenx", f), int'(screenx), m_x);
            chk($sformatf("rnd%0d_screeny", f), int'(screeny), m_y);
            chk($sformatf("rnd%0d_scrolling", f), int'(scrolling), int'(m_scr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/camera_scroll.md
Name: camera_scroll

Overview:
- Generates the `screenx`/`screeny` world-scroll offsets consumed by every per-pixel sprite/hold renderer.
- Renderers compute world pixel = (hcount+screenx, vcount+screeny).
- Once per frame, during vertical blanking, moves the camera toward the climber's world position. Uses a dead zone and a per-frame step limit, and clamps to world bounds.
- Offsets are registered and change only at frame boundaries, so no renderer sees a tear mid-frame.

Parameters:
- H_ACTIVE, 1024, visible pixels per line.
- V_ACTIVE, 768, visible lines per frame.
- WORLD_W, 2048, world width in pixels (≤ 8191).
- WORLD_H, 8000, world height in pixels (≤ 8191).
- CENTER_X, 512, screen column the climber is held near.
- CENTER_Y, 384, screen row the climber is held near.
- DEADZONE_X, 64, horizontal error tolerated without scrolling.
- DEADZONE_Y, 96, vertical error tolerated without scrolling.
- MAX_STEP, 8, maximum pixels moved per axis per frame.

Ports:
- clock  input  1  system/pixel clock.
- reset_n  input  1  asynchronous, active-low reset.
- hcount  input  11  current pixel column from the VGA timing generator.
- vcount  input  10  current line from the VGA timing generator.
- enable  input  1  1 = camera tracking active; 0 = offsets frozen.
- snap  input  1  single-cycle pulse; next update jumps straight to target.
- target_x  input  13  climber world x.
- target_y  input  13  climber world y.
- screenx  output  13  world x of screen column 0.
- screeny  output  13  world y of screen row 0.
- scrolling  output  1  1 if the last commit changed either offset.

Behaviour:
- Reset values (asserted asynchronously, immediately on reset_n=0):
  - screenx=0, screeny=WORLD_H-V_ACTIVE (7232, bottom of wall).
  - scrolling=0, snap_pending=0, state=IDLE.
- Frame strobe: fs_cond = (hcount==0 && vcount==V_ACTIVE). The strobe is the rising edge of fs_cond, using the registered previous value, so exactly one per frame even if the condition holds multiple cycles.
- snap_pending:
  - Set by snap=1 in any state.
  - Cleared in COMMIT.
  - snap arriving in the same cycle as COMMIT stays pending for the next frame.
- FSM states:
  - IDLE: on strobe && enable, go to CAPTURE. Strobe with enable=0 is ignored; outputs hold.
  - CAPTURE: latch target_x, target_y and snap_pending into working registers; go to CALC.
  - CALC:
    - desired_x = target_x - CENTER_X and desired_y = target_y - CENTER_Y, in signed 14-bit.
    - Clamp desired_x into [0, WORLD_W-H_ACTIVE] and desired_y into [0, WORLD_H-V_ACTIVE].
    - err = clamped desired - current offset (signed 14-bit).
    - Go to STEP.
  - STEP, per axis:
    - If snap latched: new = clamped desired.
    - Else if |err| ≤ DEADZONE: new = current.
    - Else: new = current + sign(err) × min(|err|-DEADZONE, MAX_STEP).
    - Go to COMMIT.
  - COMMIT: screenx/screeny ← new; scrolling ← (new ≠ old on either axis); go to IDLE.
- Latency: outputs update on the 4th rising clock edge after the strobe cycle (CAPTURE, CALC, STEP, COMMIT), well inside vertical blanking.
- Target inputs may change freely; only the CAPTURE-cycle values matter.
- Clamping guarantees outputs never leave [0, WORLD_W-H_ACTIVE] and [0, WORLD_H-V_ACTIVE]. No 13-bit wrap is possible.
- Mid-operation reset discards any in-flight update; no partial commit.
- A strobe arriving in a non-IDLE state cannot occur by construction (a frame is much longer than 4 cycles). If it does, it is ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, CAPTURE, CALC, STEP, COMMIT).
  - World and screen geometry constants, so renderers and this block agree.
  - OFFSET_W=13.
- One natural sub-module, `axis_step`: a purely per-axis clamp/dead-zone/step datapath, instantiated twice (x, y) with its own DEADZONE and MAX bound.

Test Plan:
- Reset: drop reset_n asynchronously mid-cycle -> screenx=0, screeny=7232, scrolling=0 immediately.
- Dead zone: enable=1, target_x=540, target_y=7616, one frame -> screenx=0, screeny=7232, scrolling=0.
- Step limit: target_x=1000 held -> screenx goes 8, 16, 24 on successive frames; each update lands exactly 4 cycles after the strobe; scrolling=1.
- Snap and clamp: snap pulse with target_x=4000 -> next frame screenx=1024 (clamped), in one update.
- Upward climb: target_y=0 -> screeny goes 7224, 7216, … by 8 per frame. Forcing a snap then gives screeny=0 and never below.
- Freeze and reset interaction:
  - enable=0 with target_x=2000 over 3 frames -> no change.
  - reset_n pulsed low during CALC -> reset values, and no commit that frame.
